// File: rtl/sort_pkg.sv
`timescale 1ns/1ps
// sort_pkg: shared defaults for the sort dispatcher and its arbiters.
//   SORT_NUM_ENGINES  : number of sort engines served
//   SORT_DATA_WIDTH   : job descriptor width
//   SORT_RETURN_WIDTH : completion word width
//   SORT_CNT_WIDTH    : in-flight counter width
//   ptr_w()           : width of a round-robin pointer for n requesters
package sort_pkg;

  localparam int SORT_NUM_ENGINES  = 4;
  localparam int SORT_DATA_WIDTH   = 1024;
  localparam int SORT_RETURN_WIDTH = 41;
  localparam int SORT_CNT_WIDTH    = 8;

  // A single requester still needs a 1-bit pointer so the port exists.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
// rr_arbiter: combinational round-robin pick.
// Searches i_req starting at i_ptr, upward, wrapping N-1 -> 0.
//   i_req  [N-1:0]  request vector
//   i_ptr  [PW-1:0] highest-priority index this cycle
//   o_gnt  [N-1:0]  one-hot grant (all zero when no request)
//   o_idx  [PW-1:0] binary index of the granted requester
//   o_any           at least one request present
module rr_arbiter
  import sort_pkg::*;
#(
  parameter int N  = SORT_NUM_ENGINES,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_best;
  int w_sel;
  int w_dist;

  // Pick the requester with the smallest upward distance from the pointer.
  always_comb begin
    w_best = N;
    w_sel  = 0;
    w_dist = 0;
    o_any  = 1'b0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j - int'(i_ptr) + N) % N;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = j;
        o_any  = 1'b1;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int j = 0; j < N; j++) begin
      o_gnt[j] = o_any && (j == w_sel);
    end
  end

  assign o_idx = PW'(w_sel);

endmodule

// File: rtl/sort_dispatch.sv
`timescale 1ns/1ps
// sort_dispatch: issues job descriptors to a pool of sort engines and
// merges their completion words back into a single stream.
//   clk, rst_n        clock; asynchronous active-low reset
//   dispatch_en       1 = issue allowed, 0 = drain (issue blocked only)
//   cmd_valid/ready   job descriptor handshake, cmd_data descriptor
//   eng_ready         per-engine "can take a job"
//   eng_start         one-hot start pulse, eng_data its descriptor
//   eng_cmpl_ready    per-engine completion pending
//   eng_cmpl_data     per-engine completion words, engine i at [i*RW +: RW]
//   eng_cmpl_accept   one-hot completion pop
//   cmpl_valid/ready  merged completion handshake, cmpl_data its word
//   inflight          jobs issued but not yet delivered downstream
//   idle              nothing held, nothing in flight, no completion pending
module sort_dispatch
  import sort_pkg::*;
#(
  parameter int NUM_ENGINES  = SORT_NUM_ENGINES,
  parameter int DATA_WIDTH   = SORT_DATA_WIDTH,
  parameter int RETURN_WIDTH = SORT_RETURN_WIDTH,
  parameter int CNT_WIDTH    = SORT_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              dispatch_en,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [DATA_WIDTH-1:0]             cmd_data,
  input  logic [NUM_ENGINES-1:0]            eng_ready,
  output logic [NUM_ENGINES-1:0]            eng_start,
  output logic [DATA_WIDTH-1:0]             eng_data,
  input  logic [NUM_ENGINES-1:0]            eng_cmpl_ready,
  input  logic [NUM_ENGINES*RETURN_WIDTH-1:0] eng_cmpl_data,
  output logic [NUM_ENGINES-1:0]            eng_cmpl_accept,
  output logic                              cmpl_valid,
  input  logic                              cmpl_ready,
  output logic [RETURN_WIDTH-1:0]           cmpl_data,
  output logic [CNT_WIDTH-1:0]              inflight,
  output logic                              idle
);

  localparam int PW = ptr_w(NUM_ENGINES);

  // State
  logic                   r_hold_valid;
  logic [DATA_WIDTH-1:0]  r_hold_data;
  logic [DATA_WIDTH-1:0]  r_eng_data;
  logic [NUM_ENGINES-1:0] r_started_last;
  logic [NUM_ENGINES-1:0] r_accepted_last;
  logic [PW-1:0]          r_p;
  logic [PW-1:0]          r_q;
  logic                   r_cmpl_valid;
  logic [RETURN_WIDTH-1:0] r_cmpl_data;
  logic [CNT_WIDTH-1:0]   r_inflight;

  // Issue side
  logic [NUM_ENGINES-1:0] w_ielig;
  logic [NUM_ENGINES-1:0] w_igrant;
  logic [PW-1:0]          w_iidx;
  logic                   w_iany;
  logic                   w_issue;
  logic                   w_load;

  // Completion side
  logic [NUM_ENGINES-1:0] w_celig;
  logic [NUM_ENGINES-1:0] w_cgrant;
  logic [PW-1:0]          w_cidx;
  logic                   w_cany;
  logic                   w_cap;
  logic                   w_pop;
  logic [RETURN_WIDTH-1:0] w_cslice;

  // An engine that was just started still shows eng_ready for one cycle
  // before it reacts, so it is masked out for that cycle.
  assign w_ielig = eng_ready & ~r_started_last;

  rr_arbiter #(.N(NUM_ENGINES), .PW(PW)) u_issue_arb (
    .i_req (w_ielig),
    .i_ptr (r_p),
    .o_gnt (w_igrant),
    .o_idx (w_iidx),
    .o_any (w_iany)
  );

  assign w_issue   = r_hold_valid & dispatch_en & w_iany;
  assign cmd_ready = ~r_hold_valid | w_issue;
  assign w_load    = cmd_valid & cmd_ready;

  assign eng_start = {NUM_ENGINES{w_issue}} & w_igrant;
  // Live descriptor during the issue cycle, last issued one otherwise.
  assign eng_data  = w_issue ? r_hold_data : r_eng_data;

  // Same one-cycle masking as the issue side, for completion pops.
  assign w_celig = eng_cmpl_ready & ~r_accepted_last;

  rr_arbiter #(.N(NUM_ENGINES), .PW(PW)) u_cmpl_arb (
    .i_req (w_celig),
    .i_ptr (r_q),
    .o_gnt (w_cgrant),
    .o_idx (w_cidx),
    .o_any (w_cany)
  );

  assign w_pop = r_cmpl_valid & cmpl_ready;
  // Capture only when the output slot is free or being freed this cycle.
  // The pop pulse is combinational from engine inputs, so it is also held
  // off while reset is asserted.
  assign w_cap = rst_n & w_cany & (~r_cmpl_valid | cmpl_ready);
  assign eng_cmpl_accept = {NUM_ENGINES{w_cap}} & w_cgrant;

  always_comb begin
    w_cslice = '0;
    for (int j = 0; j < NUM_ENGINES; j++) begin
      if (w_cgrant[j]) w_cslice = eng_cmpl_data[j*RETURN_WIDTH +: RETURN_WIDTH];
    end
  end

  // Hold register and issue pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid   <= 1'b0;
      r_hold_data    <= '0;
      r_eng_data     <= '0;
      r_started_last <= '0;
      r_p            <= '0;
    end else begin
      r_started_last <= eng_start;
      if (w_load) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= cmd_data;
      end else if (w_issue) begin
        r_hold_valid <= 1'b0;
      end
      if (w_issue) begin
        r_eng_data <= r_hold_data;
        r_p        <= (w_iidx == PW'(NUM_ENGINES-1)) ? '0 : w_iidx + PW'(1);
      end
    end
  end

  // Completion capture and completion pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmpl_valid    <= 1'b0;
      r_cmpl_data     <= '0;
      r_accepted_last <= '0;
      r_q             <= '0;
    end else begin
      r_accepted_last <= eng_cmpl_accept;
      if (w_cap) begin
        r_cmpl_valid <= 1'b1;
        r_cmpl_data  <= w_cslice;
        r_q          <= (w_cidx == PW'(NUM_ENGINES-1)) ? '0 : w_cidx + PW'(1);
      end else if (w_pop) begin
        r_cmpl_valid <= 1'b0;
      end
    end
  end

  // In-flight count: issue and delivery in one cycle cancel; both ends
  // saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (w_issue && !w_pop) begin
      if (r_inflight != '1) r_inflight <= r_inflight + CNT_WIDTH'(1);
    end else if (w_pop && !w_issue) begin
      if (r_inflight != '0) r_inflight <= r_inflight - CNT_WIDTH'(1);
    end
  end

  assign cmpl_valid = r_cmpl_valid;
  assign cmpl_data  = r_cmpl_data;
  assign inflight   = r_inflight;
  assign idle       = ~r_hold_valid & (r_inflight == '0) & ~r_cmpl_valid;

endmodule
